circuit2_hlsm: RTL and testbench

- Multicycle, resource-shared sequential engine computing the circuit2 datapath function (x, z from a, b, c).
- Operates under a Start/Done handshake: a driver loads operands and collects registered results.
- One shared add/sub unit and one comparator are time-multiplexed by an FSM, following the high-level state machine (HLSM) schedule.
- Sits between an operand source and a result consumer, in place of the fully parallel combinational datapath.

---
 rtl/circuit2_pkg.sv | 23 ++
 rtl/circuit2_alu.sv | 33 +++
 rtl/circuit2_hlsm.sv | 133 +++++++++++++
 tb/tb_circuit2_hlsm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/circuit2_pkg.sv
// Shared types and constants for the circuit2 multicycle engine.
// Optional build macro CIRCUIT2_SIGNED_EN selects a signed compare and arithmetic shift.
package circuit2_pkg;

    localparam int DATAWIDTH_DEF = 32;

    // Encoding 7 is unused and recovers to ST_WAIT.
    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_S1    = 3'd1,
        ST_S2    = 3'd2,
        ST_S3    = 3'd3,
        ST_S4    = 3'd4,
        ST_S5    = 3'd5,
        ST_FINAL = 3'd6
    } state_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_t;

endpackage

// File: rtl/circuit2_alu.sv
// Shared add/sub unit plus an eq/lt comparator for the circuit2 engine.
// With CIRCUIT2_SIGNED_EN defined, lt compares the operands as two's-complement values.
module circuit2_alu
    import circuit2_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic [DATAWIDTH-1:0] i_op_a,
    input  logic [DATAWIDTH-1:0] i_op_b,
    input  alu_op_t              i_op,
    output logic [DATAWIDTH-1:0] o_res,
    input  logic [DATAWIDTH-1:0] i_cmp_a,
    input  logic [DATAWIDTH-1:0] i_cmp_b,
    output logic                 o_eq,
    output logic                 o_lt
);

    logic                 w_sub;
    logic [DATAWIDTH-1:0] w_b_inv;

    // One adder serves both operations: a - b == a + ~b + 1.
    assign w_sub   = (i_op == ALU_SUB);
    assign w_b_inv = i_op_b ^ {DATAWIDTH{w_sub}};
    assign o_res   = i_op_a + w_b_inv + {{(DATAWIDTH-1){1'b0}}, w_sub};

    assign o_eq = (i_cmp_a == i_cmp_b);
`ifdef CIRCUIT2_SIGNED_EN
    assign o_lt = ($signed(i_cmp_a) < $signed(i_cmp_b));
`else
    assign o_lt = (i_cmp_a < i_cmp_b);
`endif

endmodule

// File: rtl/circuit2_hlsm.sv
// Multicycle circuit2 engine: one shared add/sub and one comparator scheduled by an FSM.
// CIRCUIT2_SIGNED_EN switches z to an arithmetic right shift (compare handled in circuit2_alu).
module circuit2_hlsm
    import circuit2_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z,
    output logic                 Done,
    output logic                 Busy
);

    state_t               r_state;
    state_t               w_next;

    logic [DATAWIDTH-1:0] r_ra, r_rb, r_rc;
    logic [DATAWIDTH-1:0] r_d, r_e, r_f, r_g, r_h;
    logic                 r_eq, r_lt;
    logic [DATAWIDTH-1:0] r_x, r_z;
    logic                 r_done;

    logic [DATAWIDTH-1:0] w_alu_b;
    alu_op_t              w_alu_op;
    logic [DATAWIDTH-1:0] w_alu_res;
    logic                 w_eq, w_lt;
    logic [DATAWIDTH-1:0] w_gsel;
    logic [DATAWIDTH-1:0] w_x, w_z;

    circuit2_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .i_op_a  (r_ra),
        .i_op_b  (w_alu_b),
        .i_op    (w_alu_op),
        .o_res   (w_alu_res),
        .i_cmp_a (r_d),
        .i_cmp_b (r_e),
        .o_eq    (w_eq),
        .o_lt    (w_lt)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= ST_WAIT;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_alu_b  = r_rb;
        w_alu_op = ALU_ADD;
        case (r_state)
            ST_WAIT:  if (Start) w_next = ST_S1;
            ST_S1:    w_next = ST_S2;
            ST_S2: begin
                w_alu_b = r_rc;
                w_next  = ST_S3;
            end
            ST_S3: begin
                w_alu_op = ALU_SUB;
                w_next   = ST_S4;
            end
            ST_S4:    w_next = ST_S5;
            ST_S5:    w_next = ST_FINAL;
            ST_FINAL: w_next = ST_WAIT;
            default:  w_next = ST_WAIT;
        endcase
    end

    // h takes the freshly muxed value, not the r_g register being written this edge.
    assign w_gsel = r_eq ? r_e : r_d;
    assign w_x    = r_g << r_lt;
`ifdef CIRCUIT2_SIGNED_EN
    assign w_z    = $unsigned($signed(r_h) >>> r_lt);
`else
    assign w_z    = r_h >> r_lt;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_rc   <= '0;
            r_d    <= '0;
            r_e    <= '0;
            r_f    <= '0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
            r_g    <= '0;
            r_h    <= '0;
            r_x    <= '0;
            r_z    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_S5);
            case (r_state)
                ST_WAIT: begin
                    if (Start) begin
                        r_ra <= a;
                        r_rb <= b;
                        r_rc <= c;
                    end
                end
                ST_S1: r_d <= w_alu_res;
                ST_S2: r_e <= w_alu_res;
                ST_S3: begin
                    r_f  <= w_alu_res;
                    r_eq <= w_eq;
                    r_lt <= w_lt;
                end
                ST_S4: begin
                    r_g <= w_gsel;
                    r_h <= r_lt ? r_f : w_gsel;
                end
                ST_S5: begin
                    r_x <= w_x;
                    r_z <= w_z;
                end
                default: ;
            endcase
        end
    end

    assign x    = r_x;
    assign z    = r_z;
    assign Done = r_done;
    assign Busy = (r_state != ST_WAIT);

endmodule

// File: tb/tb_circuit2_hlsm.sv
// Directed scoreboard bench for circuit2_hlsm; honours CIRCUIT2_SIGNED_EN in its expectations.
module tb_circuit2_hlsm;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] z;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [W-1:0] a, b, c;
    logic [W-1:0] x, z;
    logic         Done, Busy;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    circuit2_hlsm #(.DATAWIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .a     (a),
        .b     (b),
        .c     (c),
        .x     (x),
        .z     (z),
        .Done  (Done),
        .Busy  (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic);
        logic [W-1:0] d, e, f, g, h;
        logic eq, lt;
        exp_t r;
        d  = ia + ib;
        e  = ia + ic;
        f  = ia - ib;
        eq = (d == e);
`ifdef CIRCUIT2_SIGNED_EN
        lt = $signed(d) < $signed(e);
`else
        lt = d < e;
`endif
        g = eq ? e : d;
        h = lt ? f : g;
        r.x = lt ? {g[W-2:0], 1'b0} : g;
`ifdef CIRCUIT2_SIGNED_EN
        r.z = lt ? {h[W-1], h[W-1:1]} : h;
`else
        r.z = lt ? {1'b0, h[W-1:1]} : h;
`endif
        return r;
    endfunction

    // Returns 1ns after the accepting edge, with Start already dropped.
    task automatic accept(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic, input exp_t e);
        @(negedge Clk);
        a = ia; b = ib; c = ic; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        sb.push_back(e);
    endtask

    // Called just after the accepting edge; Done must show on the 6th negedge (after edge k+5).
    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (Done) begin
                n = i;
                break;
            end
            check($sformatf("%s_busy%0d", tag, i), {31'd0, Busy}, 1);
        end
        check($sformatf("%s_latency", tag), n, 6);
        check($sformatf("%s_busy_final", tag), {31'd0, Busy}, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s_x", tag), x, e.x);
            check($sformatf("%s_z", tag), z, e.z);
            last = e;
        end
        @(negedge Clk);
        check($sformatf("%s_done_pulse", tag), {31'd0, Done}, 0);
        check($sformatf("%s_idle", tag), {31'd0, Busy}, 0);
        check($sformatf("%s_hold_x", tag), x, last.x);
        check($sformatf("%s_hold_z", tag), z, last.z);
    endtask

    initial begin
        exp_t e1, e2;
        logic [W-1:0] ra, rb, rc;
        last  = '0;
        Rst   = 1'b0;
        Start = 1'b0;
        a = '0; b = '0; c = '0;
        #1;
        check("rst_x", x, 0);
        check("rst_z", z, 0);
        check("rst_done", {31'd0, Done}, 0);
        check("rst_busy", {31'd0, Busy}, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;

        accept(32'd5, 32'd3, 32'd7, '{x: 32'd16, z: 32'd1});
        collect("lt_path");

        accept(32'd4, 32'd6, 32'd6, '{x: 32'd10, z: 32'd10});
        collect("eq_path");

        accept(32'd1, 32'd9, 32'd2, '{x: 32'd10, z: 32'd10});
        collect("gt_path");

`ifdef CIRCUIT2_SIGNED_EN
        accept(32'hFFFF_FFFF, 32'd1, 32'd2, '{x: 32'd0, z: 32'hFFFF_FFFF});
`else
        accept(32'hFFFF_FFFF, 32'd1, 32'd2, '{x: 32'd0, z: 32'h7FFF_FFFF});
`endif
        collect("wrap");

        // Start held high across the whole operation with different operands.
        e1 = '{x: 32'd16, z: 32'd1};
        e2 = '{x: 32'd10, z: 32'd10};
        @(negedge Clk);
        a = 32'd5; b = 32'd3; c = 32'd7; Start = 1'b1;
        @(posedge Clk);
        #1;
        sb.push_back(e1);
        a = 32'd1; b = 32'd9; c = 32'd2;
        collect("held_first");
        @(posedge Clk);
        #1 Start = 1'b0;
        sb.push_back(e2);
        collect("held_second");

        // Asynchronous reset while in S3 aborts the operation.
        accept(32'd100, 32'd50, 32'd7, model(32'd100, 32'd50, 32'd7));
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("abort_x", x, 0);
        check("abort_z", z, 0);
        check("abort_done", {31'd0, Done}, 0);
        check("abort_busy", {31'd0, Busy}, 0);
        void'(sb.pop_back());
        last = '0;
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            check($sformatf("abort_no_done%0d", i), {31'd0, Done}, 0);
        end
        accept(32'd5, 32'd3, 32'd7, '{x: 32'd16, z: 32'd1});
        collect("post_abort");

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = (i == 0) ? rb : $urandom;
            accept(ra, rb, rc, model(ra, rb, rc));
            collect($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
